// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: SRAM-access freeze, branch flush and RAW-hazard bubble,
// plus a saturating count of cycles in which the PC is held.
module hazard_ctrl #(
  parameter int WAIT_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       src1,
  input  logic [3:0]       src2,
  input  logic             use_src1,
  input  logic             two_src,
  input  logic [3:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             forward_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  output logic             en_pc,
  output logic             en_if,
  output logic             clr_if,
  output logic             en_id,
  output logic             clr_id,
  output logic             en_back,
  output logic             mem_ready,
  output logic             hazard,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [7:0] LP_WAIT_M1 = 8'(WAIT_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_stall;
  logic             w_freeze, w_m1, w_m2, w_ld1, w_ld2, w_hazard;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // DONE never samples mem_req: the request that just completed is still asserted.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: if (mem_req) begin
        if (WAIT_CYCLES > 1) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = LP_WAIT_M1;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 8'd1;
        if (r_cnt == 8'd1) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_freeze = ((r_state == S_IDLE) && mem_req) || (r_state == S_WAIT);

  assign w_m1  = use_src1 && ((exe_wb_en && src1 == exe_dest) || (mem_wb_en && src1 == mem_dest));
  assign w_m2  = two_src  && ((exe_wb_en && src2 == exe_dest) || (mem_wb_en && src2 == mem_dest));
  assign w_ld1 = use_src1 && (src1 == exe_dest);
  assign w_ld2 = two_src  && (src2 == exe_dest);
  // With forwarding only a load in EXE cannot supply its result in time.
  assign w_hazard = forward_en ? (exe_mem_r_en && exe_wb_en && (w_ld1 || w_ld2))
                               : (w_m1 || w_m2);

  always_comb begin
    en_pc   = 1'b1;
    en_if   = 1'b1;
    clr_if  = 1'b0;
    en_id   = 1'b1;
    clr_id  = 1'b0;
    en_back = 1'b1;
    if (!rst) begin
      en_pc   = 1'b0;
      en_if   = 1'b0;
      en_id   = 1'b0;
      en_back = 1'b0;
    end else if (w_freeze) begin
      en_pc   = 1'b0;
      en_if   = 1'b0;
      en_id   = 1'b0;
      en_back = 1'b0;
    end else if (branch_taken) begin
      clr_if = 1'b1;
      clr_id = 1'b1;
    end else if (w_hazard) begin
      en_pc  = 1'b0;
      en_if  = 1'b0;
      clr_id = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_stall <= '0;
    else if (!en_pc && r_stall != {CNT_W{1'b1}}) r_stall <= r_stall + 1'b1;
  end

  assign mem_ready = rst && (r_state == S_DONE);
  assign hazard    = w_hazard;
  assign stall_cnt = r_stall;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (WAIT_CYCLES=4, CNT_W=4 so saturation is reachable).
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] src1 = '0, src2 = '0, exe_dest = '0, mem_dest = '0;
  logic       use_src1 = 0, two_src = 0, exe_wb_en = 0, exe_mem_r_en = 0;
  logic       mem_wb_en = 0, forward_en = 0, branch_taken = 0, mem_req = 0;
  logic       en_pc, en_if, clr_if, en_id, clr_id, en_back, mem_ready, hazard;
  logic [3:0] stall_cnt;
  logic [5:0] ctl;
  int total = 0, bad = 0;

  localparam logic [5:0] FRZ = 6'b000000, FLUSH = 6'b111111, BUB = 6'b000111, RUN = 6'b110101;

  hazard_ctrl #(.WAIT_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .use_src1(use_src1), .two_src(two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .forward_en(forward_en),
    .branch_taken(branch_taken), .mem_req(mem_req), .en_pc(en_pc), .en_if(en_if),
    .clr_if(clr_if), .en_id(en_id), .clr_id(clr_id), .en_back(en_back),
    .mem_ready(mem_ready), .hazard(hazard), .stall_cnt(stall_cnt)
  );

  assign ctl = {en_pc, en_if, clr_if, en_id, clr_id, en_back};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_id();
    src1 = 0; src2 = 0; exe_dest = 0; mem_dest = 0; use_src1 = 0; two_src = 0;
    exe_wb_en = 0; exe_mem_r_en = 0; mem_wb_en = 0; forward_en = 0; branch_taken = 0;
  endtask

  task automatic test_reset();
    forward_en = 0; use_src1 = 1; src1 = 4'd5; exe_dest = 4'd5; exe_wb_en = 1;
    tick(); tick(); #1;
    total++; if (ctl !== FRZ) begin bad++; $display("FAIL reset_ctl got=%b want=%b", ctl, FRZ); end
    total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", mem_ready); end
    total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", stall_cnt); end
    total++; if (hazard !== 1'b1) begin bad++; $display("FAIL reset_hazard got=%b want=1", hazard); end
    clear_id(); rst = 1; #1;
    total++; if (ctl !== RUN) begin bad++; $display("FAIL post_reset_ctl got=%b want=%b", ctl, RUN); end
  endtask

  task automatic test_mem_freeze();
    mem_req = 1; #1;
    for (int i = 0; i < 4; i++) begin
      total++; if (ctl !== FRZ || mem_ready !== 1'b0) begin bad++; $display("FAIL freeze_cyc%0d ctl=%b rdy=%b want=%b/0", i, ctl, mem_ready, FRZ); end
      tick();
    end
    total++; if (mem_ready !== 1'b1 || ctl !== RUN) begin bad++; $display("FAIL done_cyc rdy=%b ctl=%b want=1/%b", mem_ready, ctl, RUN); end
    total++; if (stall_cnt !== 4'd4) begin bad++; $display("FAIL freeze_cnt got=%0d want=4", stall_cnt); end
    mem_req = 0; tick();
    total++; if (mem_ready !== 1'b0 || ctl !== RUN) begin bad++; $display("FAIL idle_after rdy=%b ctl=%b want=0/%b", mem_ready, ctl, RUN); end
  endtask

  task automatic test_raw_nofwd();
    clear_id(); use_src1 = 1; src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1; #1;
    total++; if (ctl !== BUB || hazard !== 1'b1) begin bad++; $display("FAIL raw_exe ctl=%b hz=%b want=%b/1", ctl, hazard, BUB); end
    tick();
    total++; if (stall_cnt !== 4'd5) begin bad++; $display("FAIL raw_cnt got=%0d want=5", stall_cnt); end
    clear_id(); two_src = 1; src2 = 4'd9; mem_dest = 4'd9; mem_wb_en = 1; exe_dest = 4'd9; #1;
    total++; if (ctl !== BUB || hazard !== 1'b1) begin bad++; $display("FAIL raw_mem_src2 ctl=%b hz=%b want=%b/1", ctl, hazard, BUB); end
    mem_wb_en = 0; exe_wb_en = 1; exe_dest = 4'd8; use_src1 = 0; src1 = 4'd8; #1;
    total++; if (ctl !== RUN || hazard !== 1'b0) begin bad++; $display("FAIL raw_nomatch ctl=%b hz=%b want=%b/0", ctl, hazard, RUN); end
    tick();
  endtask

  task automatic test_raw_fwd();
    clear_id(); forward_en = 1; use_src1 = 1; src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1; #1;
    total++; if (ctl !== RUN || hazard !== 1'b0) begin bad++; $display("FAIL fwd_alu ctl=%b hz=%b want=%b/0", ctl, hazard, RUN); end
    exe_mem_r_en = 1; #1;
    total++; if (ctl !== BUB || hazard !== 1'b1) begin bad++; $display("FAIL fwd_load ctl=%b hz=%b want=%b/1", ctl, hazard, BUB); end
    tick();
    total++; if (stall_cnt !== 4'd6) begin bad++; $display("FAIL fwd_cnt got=%0d want=6", stall_cnt); end
    clear_id(); forward_en = 1; two_src = 1; src2 = 4'd7; mem_dest = 4'd7; mem_wb_en = 1;
    exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 4'd2; #1;
    total++; if (ctl !== RUN || hazard !== 1'b0) begin bad++; $display("FAIL fwd_mem_only ctl=%b hz=%b want=%b/0", ctl, hazard, RUN); end
    tick();
  endtask

  task automatic test_branch();
    clear_id(); use_src1 = 1; src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1; branch_taken = 1; #1;
    total++; if (ctl !== FLUSH || hazard !== 1'b1) begin bad++; $display("FAIL br_hz ctl=%b hz=%b want=%b/1", ctl, hazard, FLUSH); end
    tick();
    total++; if (stall_cnt !== 4'd6) begin bad++; $display("FAIL br_cnt got=%0d want=6", stall_cnt); end
  endtask

  task automatic test_mem_vs_branch();
    clear_id(); branch_taken = 1; mem_req = 1; #1;
    for (int i = 0; i < 4; i++) begin
      total++; if (ctl !== FRZ) begin bad++; $display("FAIL mb_freeze%0d got=%b want=%b", i, ctl, FRZ); end
      tick();
    end
    total++; if (ctl !== FLUSH || mem_ready !== 1'b1) begin bad++; $display("FAIL mb_flush ctl=%b rdy=%b want=%b/1", ctl, mem_ready, FLUSH); end
    mem_req = 0; branch_taken = 0; tick();
    total++; if (stall_cnt !== 4'd10) begin bad++; $display("FAIL mb_cnt got=%0d want=10", stall_cnt); end
  endtask

  task automatic test_reset_in_wait();
    clear_id(); mem_req = 1; tick(); tick();
    rst = 0; #1;
    total++; if (ctl !== FRZ || mem_ready !== 1'b0 || stall_cnt !== 4'd0) begin bad++; $display("FAIL async_rst ctl=%b rdy=%b cnt=%0d want=%b/0/0", ctl, mem_ready, stall_cnt, FRZ); end
    tick(); #2; rst = 1; #1;
    for (int i = 0; i < 4; i++) begin
      total++; if (ctl !== FRZ || mem_ready !== 1'b0) begin bad++; $display("FAIL refreeze%0d ctl=%b rdy=%b want=%b/0", i, ctl, mem_ready, FRZ); end
      tick();
    end
    total++; if (mem_ready !== 1'b1 || stall_cnt !== 4'd4) begin bad++; $display("FAIL refreeze_done rdy=%b cnt=%0d want=1/4", mem_ready, stall_cnt); end
    mem_req = 0; tick();
    use_src1 = 1; src1 = 4'd1; exe_dest = 4'd1; exe_wb_en = 1;
    for (int i = 0; i < 10; i++) tick();
    total++; if (stall_cnt !== 4'd14) begin bad++; $display("FAIL sat_pre got=%0d want=14", stall_cnt); end
    for (int i = 0; i < 5; i++) tick();
    total++; if (stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_hold got=%0d want=15", stall_cnt); end
    clear_id();
  endtask

  initial begin
    test_reset();
    test_mem_freeze();
    test_raw_nofwd();
    test_raw_fwd();
    test_branch();
    test_mem_vs_branch();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
